dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU MEM stage and the slow 256-bit-line main data memory.
- Serves hits combinationally, with the array updated at the clock edge.
- On a miss it asserts a stall to freeze the whole pipeline, writes back a dirty victim if needed, refills the line, then completes the access.

Parameters:
- NUM_LINES, 32, number of cache lines (power of 2); index width IDX_W = log2(NUM_LINES).
- LINE_W, 256, line width in bits (8 words); offset is 5 bits.
- ADDR_W, 32, byte address width; tag width = ADDR_W - IDX_W - 5.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- p1_addr_i  in  ADDR_W  byte address from the EXMEM ALU result
- p1_data_i  in  32  store data
- p1_MemRead_i  in  1  load request
- p1_MemWrite_i  in  1  store request
- p1_data_o  out  32  load data
- p1_stall_o  out  1  freeze PC, IFID, IDEX, EXMEM and MEMWB while high
- mem_addr_o  out  ADDR_W  line-aligned memory address (low 5 bits 0)
- mem_data_o  out  LINE_W  write-back line
- mem_enable_o  out  1  memory request valid
- mem_write_o  out  1  1 = write, 0 = read
- mem_data_i  in  LINE_W  refill line
- mem_ack_i  in  1  single-cycle completion pulse
- hit_cnt_o  out  32  see Optional Feature
- miss_cnt_o  out  32  see Optional Feature

Behaviour:
- Address split: tag = addr[ADDR_W-1:IDX_W+5], index = addr[IDX_W+4:5], word = addr[4:2]. Byte bits [1:0] are ignored (word accesses only).
- Per line: valid, dirty, tag, LINE_W data.
- Reset (rst_i low, asynchronous):
  - all valid and dirty bits 0; FSM in IDLE.
  - p1_stall_o=0, p1_data_o=0, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, counters 0.
  - Data and tag arrays are not reset.
- req = p1_MemRead_i | p1_MemWrite_i. hit = valid & (tag match). If both read and write are high, treat as write.
- p1_stall_o = req & ~hit & (state==IDLE), OR'd with (state != IDLE). It is combinational, so a miss stalls in the same cycle it is presented.
- Hit, IDLE:
  - load: p1_data_o = selected word, same cycle, no stall.
  - store: the word is written and dirty set at the next edge.
  - No request: p1_data_o holds its last value.
- FSM states: IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE.
  - IDLE -> MISS on req & ~hit.
  - MISS: if victim valid & dirty -> WRITEBACK, otherwise -> REFILL. Takes 1 cycle, no memory request.
  - WRITEBACK:
    - mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o = victim line.
    - Held stable until mem_ack_i, then -> REFILL.
  - REFILL:
    - mem_enable_o=1, mem_write_o=0, mem_addr_o = {req tag, index, 5'b0}.
    - On mem_ack_i: capture mem_data_i into the line; valid=1, dirty=0, tag updated; -> REFILL_DONE.
  - REFILL_DONE: 1 cycle, still stalling. Next edge -> IDLE, where the access now hits and completes.
- mem_enable_o deasserts in the cycle after ack. Memory is never issued back-to-back requests without leaving the current state.
- Miss latency: 3 + ackLatency cycles when clean; add a further ackLatency + 1 when dirty.
- mem_ack_i outside WRITEBACK/REFILL is ignored.
- CPU inputs must be held stable while p1_stall_o=1; changes during a miss are not tracked.
- Reset mid-miss aborts the transaction immediately. The line being refilled stays invalid.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined:
  - hit_cnt_o increments once per access that completes in IDLE without stalling, including the post-refill completion.
  - miss_cnt_o increments on every IDLE->MISS transition.
  - Both wrap at 2^32.
- Undefined: both outputs are tied to 0 and no counter flops are synthesized.

Test Plan:
- Cold load addr 0x0000_0040, memory line word0 = 0x1234_5678, ack 10 cycles after enable:
  - stall rises same cycle; no WRITEBACK; mem_addr_o=0x40, mem_write_o=0;
  - p1_data_o=0x1234_5678 once stall drops; miss_cnt=1, hit_cnt=1.
- Store 0xDEAD_BEEF to 0x44, then load 0x44:
  - both hit with zero stall; load returns 0xDEAD_BEEF;
  - the line's dirty bit is set.
- Load 0x0000_0444 (same index 2, different tag) after the dirty store:
  - WRITEBACK to mem_addr_o=0x40 with word1 = 0xDEAD_BEEF, then REFILL from 0x440;
  - stall lasts 3 + 2*ackLatency + 1 cycles.
- Assert rst_i low during REFILL:
  - outputs return to reset values immediately;
  - re-issuing the same load misses again and refills correctly.
- Assert mem_ack_i spuriously while in IDLE:
  - no state change, no array update.
- Issue p1_MemRead_i and p1_MemWrite_i together on a hit:
  - a write is performed; dirty set.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache with a blocking miss FSM.
// Define DCACHE_STATS_EN to build the hit/miss counters; otherwise they read 0.
module dcache_ctrl #(
   parameter int NUM_LINES = 32,
   parameter int LINE_W    = 256,
   parameter int ADDR_W    = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] p1_addr_i,
   input  logic [31:0]       p1_data_i,
   input  logic              p1_MemRead_i,
   input  logic              p1_MemWrite_i,
   output logic [31:0]       p1_data_o,
   output logic              p1_stall_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i,
   output logic [31:0]       hit_cnt_o,
   output logic [31:0]       miss_cnt_o
);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = ADDR_W - IDX_W - 5;

   typedef enum logic [2:0] {
      IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE
   } state_e;

   state_e              state_q;
   logic [NUM_LINES-1:0] valid_q, dirty_q;
   logic [TAG_W-1:0]    tag_arr [NUM_LINES];
   logic [LINE_W-1:0]   data_arr [NUM_LINES];
   logic [31:0]         rdata_q;
   logic                en_q, we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [LINE_W-1:0]   wdata_q;

   logic [TAG_W-1:0]    req_tag;
   logic [IDX_W-1:0]    idx;
   logic [2:0]          word;
   logic [LINE_W-1:0]   line;
   logic [31:0]         rd_word;
   logic                req, rd, wr, hit, idle;
   logic                rd_hit, wr_hit, fill;
   logic                unused_bits;

   assign req_tag = p1_addr_i[ADDR_W-1:IDX_W+5];
   assign idx     = p1_addr_i[IDX_W+4:5];
   assign word    = p1_addr_i[4:2];
   assign unused_bits = ^p1_addr_i[1:0];

   assign wr   = p1_MemWrite_i;
   assign rd   = p1_MemRead_i & ~p1_MemWrite_i;
   assign req  = p1_MemRead_i | p1_MemWrite_i;
   assign line = data_arr[idx];
   assign hit  = valid_q[idx] & (tag_arr[idx] == req_tag);
   assign idle = (state_q == IDLE);

   assign rd_word = line[{word, 5'b0} +: 32];
   assign rd_hit  = idle & rd & hit;
   assign wr_hit  = idle & wr & hit;
   // A refill beat only counts once the request is actually on the bus.
   assign fill    = (state_q == REFILL) & en_q & mem_ack_i;

   assign p1_stall_o   = (req & ~hit & idle) | ~idle;
   assign p1_data_o    = rd_hit ? rd_word : rdata_q;
   assign mem_addr_o   = addr_q;
   assign mem_data_o   = wdata_q;
   assign mem_enable_o = en_q;
   assign mem_write_o  = we_q;

   always_ff @(posedge clk_i) begin
      if (fill) begin
         data_arr[idx] <= mem_data_i;
         tag_arr[idx]  <= req_tag;
      end else if (wr_hit) begin
         data_arr[idx][{word, 5'b0} +: 32] <= p1_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         valid_q <= '0;
         dirty_q <= '0;
         rdata_q <= '0;
         en_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req & ~hit) state_q <= MISS;
               if (wr_hit) dirty_q[idx] <= 1'b1;
               if (rd_hit) rdata_q <= rd_word;
            end
            MISS: begin
               en_q <= 1'b1;
               if (valid_q[idx] & dirty_q[idx]) begin
                  state_q <= WRITEBACK;
                  we_q    <= 1'b1;
                  addr_q  <= {tag_arr[idx], idx, 5'b0};
                  wdata_q <= line;
               end else begin
                  state_q <= REFILL;
                  we_q    <= 1'b0;
                  addr_q  <= {req_tag, idx, 5'b0};
               end
            end
            WRITEBACK: begin
               if (mem_ack_i) begin
                  state_q <= REFILL;
                  en_q    <= 1'b0;
                  we_q    <= 1'b0;
                  addr_q  <= {req_tag, idx, 5'b0};
               end
            end
            // One idle bus cycle separates the write-back from the refill read.
            REFILL: begin
               if (!en_q) begin
                  en_q <= 1'b1;
               end else if (mem_ack_i) begin
                  en_q         <= 1'b0;
                  valid_q[idx] <= 1'b1;
                  dirty_q[idx] <= 1'b0;
                  state_q      <= REFILL_DONE;
               end
            end
            REFILL_DONE: state_q <= IDLE;
            default:     state_q <= IDLE;
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_q, miss_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else if (idle & req) begin
         if (hit) hit_q  <= hit_q + 32'd1;
         else     miss_q <= miss_q + 32'd1;
      end
   end

   assign hit_cnt_o  = hit_q;
   assign miss_cnt_o = miss_q;
`else
   assign hit_cnt_o  = '0;
   assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a fixed-latency line memory model.
// Memory acks on the LAT-th consecutive cycle that mem_enable_o is high.
module tb_dcache_ctrl;
   localparam int LAT = 10;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b0;
   logic [31:0]  p1_addr_i = '0;
   logic [31:0]  p1_data_i = '0;
   logic         p1_MemRead_i = 1'b0;
   logic         p1_MemWrite_i = 1'b0;
   logic [31:0]  p1_data_o;
   logic         p1_stall_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic         mem_enable_o;
   logic         mem_write_o;
   logic [255:0] mem_data_i = '0;
   logic         mem_ack_i = 1'b0;
   logic [31:0]  hit_cnt_o;
   logic [31:0]  miss_cnt_o;

   dcache_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
      .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
      .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
      .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
      .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int           n_checks = 0;
   int           n_fail = 0;
   logic [255:0] mem [int];
   bit           auto_ack = 1'b1;
   int           en_cnt = 0;
   int           wr_cnt = 0;
   logic [31:0]  last_wr_addr = '0;
   logic [31:0]  last_rd_addr = '0;
   logic [255:0] last_wb = '0;

   always @(negedge clk_i) begin
      if (auto_ack) begin
         mem_ack_i = 1'b0;
         if (mem_enable_o) begin
            en_cnt++;
            if (en_cnt == LAT) begin
               en_cnt = 0;
               mem_ack_i = 1'b1;
               if (mem_write_o) begin
                  mem[int'(mem_addr_o >> 5)] = mem_data_o;
                  last_wb = mem_data_o;
                  last_wr_addr = mem_addr_o;
                  wr_cnt++;
               end else begin
                  mem_data_i = mem[int'(mem_addr_o >> 5)];
                  last_rd_addr = mem_addr_o;
               end
            end
         end else begin
            en_cnt = 0;
         end
      end
   end

   function automatic logic [31:0] cexp(input int x);
`ifdef DCACHE_STATS_EN
      return 32'(x);
`else
      return (x > 0) ? 32'd0 : 32'd0;
`endif
   endfunction

   task automatic drive(input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d);
      @(negedge clk_i);
      p1_MemRead_i = r;
      p1_MemWrite_i = w;
      p1_addr_i = a;
      p1_data_i = d;
      #1;
   endtask

   task automatic idle_req();
      @(negedge clk_i);
      p1_MemRead_i = 1'b0;
      p1_MemWrite_i = 1'b0;
      #1;
   endtask

   task automatic wait_stall(output int n);
      n = 0;
      while (p1_stall_o === 1'b1 && n < 100) begin
         n++;
         @(negedge clk_i);
         #1;
      end
   endtask

   task automatic test_reset();
      #2;
      n_checks++; if (p1_stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b want 0", p1_stall_o); end
      n_checks++; if (p1_data_o !== 32'h0) begin n_fail++; $display("FAIL rst_data got %h want 0", p1_data_o); end
      n_checks++; if (mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL rst_en got %b want 0", mem_enable_o); end
      n_checks++; if (mem_write_o !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b want 0", mem_write_o); end
      n_checks++; if (mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_addr got %h want 0", mem_addr_o); end
      n_checks++; if (mem_data_o !== 256'h0) begin n_fail++; $display("FAIL rst_mdata got %h want 0", mem_data_o); end
      n_checks++; if (hit_cnt_o !== 32'h0 || miss_cnt_o !== 32'h0) begin n_fail++; $display("FAIL rst_cnt got %0d/%0d want 0/0", hit_cnt_o, miss_cnt_o); end
      @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   task automatic test_cold_load();
      int n;
      drive(1, 0, 32'h0000_0040, 0);
      n_checks++; if (p1_stall_o !== 1'b1) begin n_fail++; $display("FAIL cold_stall_rise got %b want 1", p1_stall_o); end
      wait_stall(n);
      n_checks++; if (n != 3 + LAT) begin n_fail++; $display("FAIL cold_stall_len got %0d want %0d", n, 3 + LAT); end
      n_checks++; if (wr_cnt != 0) begin n_fail++; $display("FAIL cold_no_wb got %0d want 0", wr_cnt); end
      n_checks++; if (last_rd_addr !== 32'h40) begin n_fail++; $display("FAIL cold_rd_addr got %h want 40", last_rd_addr); end
      n_checks++; if (p1_data_o !== 32'h1234_5678) begin n_fail++; $display("FAIL cold_data got %h want 12345678", p1_data_o); end
      idle_req();
      n_checks++; if (p1_data_o !== 32'h1234_5678) begin n_fail++; $display("FAIL cold_hold got %h want 12345678", p1_data_o); end
      n_checks++; if (miss_cnt_o !== cexp(1) || hit_cnt_o !== cexp(1)) begin n_fail++; $display("FAIL cold_cnt got %0d/%0d want %0d/%0d", miss_cnt_o, hit_cnt_o, cexp(1), cexp(1)); end
   endtask

   task automatic test_store_hit();
      drive(0, 1, 32'h0000_0044, 32'hDEAD_BEEF);
      n_checks++; if (p1_stall_o !== 1'b0) begin n_fail++; $display("FAIL st_stall got %b want 0", p1_stall_o); end
      drive(1, 0, 32'h0000_0044, 0);
      n_checks++; if (p1_stall_o !== 1'b0) begin n_fail++; $display("FAIL ld_stall got %b want 0", p1_stall_o); end
      n_checks++; if (p1_data_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ld_data got %h want deadbeef", p1_data_o); end
      idle_req();
   endtask

   task automatic test_dirty_evict();
      int n;
      drive(1, 0, 32'h0000_0444, 0);
      wait_stall(n);
      n_checks++; if (n != 3 + 2 * LAT + 1) begin n_fail++; $display("FAIL ev_stall_len got %0d want %0d", n, 3 + 2 * LAT + 1); end
      n_checks++; if (wr_cnt != 1) begin n_fail++; $display("FAIL ev_wb_cnt got %0d want 1", wr_cnt); end
      n_checks++; if (last_wr_addr !== 32'h40) begin n_fail++; $display("FAIL ev_wb_addr got %h want 40", last_wr_addr); end
      n_checks++; if (last_wb[63:32] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ev_wb_w1 got %h want deadbeef", last_wb[63:32]); end
      n_checks++; if (last_wb[31:0] !== 32'h1234_5678) begin n_fail++; $display("FAIL ev_wb_w0 got %h want 12345678", last_wb[31:0]); end
      n_checks++; if (last_rd_addr !== 32'h440) begin n_fail++; $display("FAIL ev_rd_addr got %h want 440", last_rd_addr); end
      n_checks++; if (p1_data_o !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL ev_data got %h want 0badf00d", p1_data_o); end
      idle_req();
      n_checks++; if (miss_cnt_o !== cexp(2) || hit_cnt_o !== cexp(4)) begin n_fail++; $display("FAIL ev_cnt got %0d/%0d want %0d/%0d", miss_cnt_o, hit_cnt_o, cexp(2), cexp(4)); end
   endtask

   task automatic test_reset_mid_refill();
      int n;
      int k;
      drive(1, 0, 32'h0000_0844, 0);
      k = 0;
      while (!(mem_enable_o === 1'b1 && mem_write_o === 1'b0) && k < 50) begin
         k++;
         @(negedge clk_i);
         #1;
      end
      n_checks++; if (k >= 50) begin n_fail++; $display("FAIL mid_reach_refill got timeout want refill"); end
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      p1_MemRead_i = 1'b0;
      #1;
      n_checks++; if (p1_stall_o !== 1'b0) begin n_fail++; $display("FAIL mid_stall got %b want 0", p1_stall_o); end
      n_checks++; if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0) begin n_fail++; $display("FAIL mid_en got %b%b want 00", mem_enable_o, mem_write_o); end
      n_checks++; if (mem_addr_o !== 32'h0 || p1_data_o !== 32'h0) begin n_fail++; $display("FAIL mid_regs got %h/%h want 0/0", mem_addr_o, p1_data_o); end
      n_checks++; if (hit_cnt_o !== 32'h0 || miss_cnt_o !== 32'h0) begin n_fail++; $display("FAIL mid_cnt got %0d/%0d want 0/0", hit_cnt_o, miss_cnt_o); end
      @(negedge clk_i);
      rst_i = 1'b1;
      drive(1, 0, 32'h0000_0844, 0);
      n_checks++; if (p1_stall_o !== 1'b1) begin n_fail++; $display("FAIL re_miss got %b want 1", p1_stall_o); end
      wait_stall(n);
      n_checks++; if (n != 3 + LAT) begin n_fail++; $display("FAIL re_stall_len got %0d want %0d", n, 3 + LAT); end
      n_checks++; if (p1_data_o !== 32'h5555_AAAA) begin n_fail++; $display("FAIL re_data got %h want 5555aaaa", p1_data_o); end
      n_checks++; if (last_rd_addr !== 32'h840) begin n_fail++; $display("FAIL re_rd_addr got %h want 840", last_rd_addr); end
      drive(1, 0, 32'h0000_0044, 0);
      wait_stall(n);
      n_checks++; if (n != 3 + LAT) begin n_fail++; $display("FAIL re44_stall_len got %0d want %0d", n, 3 + LAT); end
      n_checks++; if (p1_data_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL re44_data got %h want deadbeef", p1_data_o); end
      idle_req();
      n_checks++; if (miss_cnt_o !== cexp(2) || hit_cnt_o !== cexp(2)) begin n_fail++; $display("FAIL re_cnt got %0d/%0d want %0d/%0d", miss_cnt_o, hit_cnt_o, cexp(2), cexp(2)); end
   endtask

   task automatic test_spurious_ack();
      auto_ack = 1'b0;
      @(negedge clk_i);
      mem_data_i = {8{32'hFFFF_0000}};
      mem_ack_i = 1'b1;
      repeat (2) @(negedge clk_i);
      mem_ack_i = 1'b0;
      #1;
      n_checks++; if (p1_stall_o !== 1'b0 || mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL spur_state got %b%b want 00", p1_stall_o, mem_enable_o); end
      auto_ack = 1'b1;
      drive(1, 0, 32'h0000_0044, 0);
      n_checks++; if (p1_stall_o !== 1'b0) begin n_fail++; $display("FAIL spur_hit got %b want 0", p1_stall_o); end
      n_checks++; if (p1_data_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL spur_data got %h want deadbeef", p1_data_o); end
      idle_req();
   endtask

   task automatic test_rw_both();
      int n;
      drive(1, 1, 32'h0000_0048, 32'h7777_8888);
      n_checks++; if (p1_stall_o !== 1'b0) begin n_fail++; $display("FAIL rw_stall got %b want 0", p1_stall_o); end
      n_checks++; if (p1_data_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rw_noread got %h want deadbeef", p1_data_o); end
      drive(1, 0, 32'h0000_0048, 0);
      n_checks++; if (p1_data_o !== 32'h7777_8888) begin n_fail++; $display("FAIL rw_data got %h want 77778888", p1_data_o); end
      drive(1, 0, 32'h0000_0C48, 0);
      wait_stall(n);
      n_checks++; if (n != 3 + 2 * LAT + 1) begin n_fail++; $display("FAIL rw_dirty_len got %0d want %0d", n, 3 + 2 * LAT + 1); end
      n_checks++; if (wr_cnt != 2 || last_wr_addr !== 32'h40) begin n_fail++; $display("FAIL rw_wb got %0d@%h want 2@40", wr_cnt, last_wr_addr); end
      n_checks++; if (last_wb[95:64] !== 32'h7777_8888) begin n_fail++; $display("FAIL rw_wb_w2 got %h want 77778888", last_wb[95:64]); end
      n_checks++; if (p1_data_o !== 32'h3333_0C48 || last_rd_addr !== 32'hC40) begin n_fail++; $display("FAIL rw_refill got %h@%h want 33330c48@c40", p1_data_o, last_rd_addr); end
      idle_req();
      n_checks++; if (miss_cnt_o !== cexp(3) || hit_cnt_o !== cexp(6)) begin n_fail++; $display("FAIL rw_cnt got %0d/%0d want %0d/%0d", miss_cnt_o, hit_cnt_o, cexp(3), cexp(6)); end
   endtask

   initial begin
      logic [255:0] l;
      l = '0; l[31:0] = 32'h1234_5678; l[63:32] = 32'hAAAA_0001;
      mem[2] = l;
      l = '0; l[63:32] = 32'h0BAD_F00D;
      mem[34] = l;
      l = '0; l[63:32] = 32'h5555_AAAA;
      mem[66] = l;
      l = '0; l[95:64] = 32'h3333_0C48;
      mem[98] = l;
      test_reset();
      test_cold_load();
      test_store_hit();
      test_dirty_evict();
      test_reset_mid_refill();
      test_spurious_ack();
      test_rw_both();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
